// File: rtl/fe_capture_packer_if.sv
// Capture packer port bundle: control, front-end event inputs and the FIFO write port.
// The packer drives through master; the environment/FIFO side uses slave.
interface fe_capture_packer_if #(
    parameter int pCOUNT_BITS = 14
);
    logic                   I_arm;
    logic                   I_abort;
    logic                   I_trigger;
    logic [pCOUNT_BITS-1:0] I_max_words;
    logic                   I_event_valid;
    logic [7:0]             I_event_data;
    logic [7:0]             I_status;
    logic                   I_fifo_full;
    logic [17:0]            O_data;
    logic                   O_wr;
    logic                   O_armed;
    logic                   O_capturing;
    logic                   O_capture_done;
    logic                   O_drop_sticky;

    modport master (
        input  I_arm, I_abort, I_trigger, I_max_words, I_event_valid,
               I_event_data, I_status, I_fifo_full,
        output O_data, O_wr, O_armed, O_capturing, O_capture_done, O_drop_sticky
    );

    modport slave (
        output I_arm, I_abort, I_trigger, I_max_words, I_event_valid,
               I_event_data, I_status, I_fifo_full,
        input  O_data, O_wr, O_armed, O_capturing, O_capture_done, O_drop_sticky
    );
endinterface

// File: rtl/fe_capture_packer.sv
// Front-end capture formatter: turns data events and status changes into
// 18-bit tagged, timestamped FIFO words, with idle, drop and length accounting.
module fe_capture_packer #(
    parameter int pTS_BITS    = 8,
    parameter int pCOUNT_BITS = 14
) (
    input  logic                fe_clk,
    input  logic                reset_n,
    fe_capture_packer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                 state;
    logic [pTS_BITS-1:0]    ts;
    logic [15:0]            time_cnt;
    logic [15:0]            drop_cnt;
    logic [pCOUNT_BITS-1:0] wcnt;
    logic [7:0]             status_ref;
    logic                   ref_ok;
    logic                   pend;
    logic [7:0]             pend_val;
    logic                   wr_q;
    logic [17:0]            data_q;
    logic                   sticky_q;

    logic                   cap, mark_go, data_go, stat_go, time_go;
    logic                   produce, wr_go, stat_chg;
    logic [7:0]             delta;
    logic [17:0]            word;
    logic [15:0]            time_nxt, drop_nxt;
    logic [pCOUNT_BITS-1:0] wcnt_nxt;

    // One producer per cycle, MARK > DATA > pending STAT > TIME.
    always_comb begin
        cap      = (state == CAPTURE) && !bus.I_abort;
        mark_go  = cap && (drop_cnt != 16'd0) && !bus.I_fifo_full;
        data_go  = cap && bus.I_event_valid && !mark_go;
        stat_go  = cap && pend && !mark_go && !data_go;
        time_go  = cap && (&ts) && !mark_go && !data_go && !stat_go;
        produce  = mark_go || data_go || stat_go || time_go;
        wr_go    = produce && !bus.I_fifo_full;
        stat_chg = ref_ok && (bus.I_status != status_ref);
        delta    = 8'(ts);
        time_nxt = (&time_cnt) ? time_cnt : time_cnt + 16'd1;
        drop_nxt = (&drop_cnt) ? drop_cnt : drop_cnt + 16'd1;
        wcnt_nxt = wcnt + 1'b1;
        word     = '0;
        if (mark_go)      word = {2'b11, drop_cnt};
        else if (data_go) word = {2'b00, delta, bus.I_event_data};
        else if (stat_go) word = {2'b01, delta, pend_val};
        else if (time_go) word = {2'b10, time_nxt};
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ts         <= '0;
            time_cnt   <= '0;
            drop_cnt   <= '0;
            wcnt       <= '0;
            status_ref <= '0;
            ref_ok     <= 1'b0;
            pend       <= 1'b0;
            pend_val   <= '0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            sticky_q   <= 1'b0;
        end else begin
            status_ref <= bus.I_status;
            ref_ok     <= 1'b1;
            wr_q       <= 1'b0;
            data_q     <= '0;
            if (bus.I_abort) begin
                state    <= IDLE;
                ts       <= '0;
                time_cnt <= '0;
                drop_cnt <= '0;
                wcnt     <= '0;
                pend     <= 1'b0;
                sticky_q <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (bus.I_arm) begin
                            state    <= ARMED;
                            wcnt     <= '0;
                            drop_cnt <= '0;
                            sticky_q <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (bus.I_trigger) begin
                            state    <= CAPTURE;
                            ts       <= '0;
                            time_cnt <= '0;
                            pend     <= 1'b0;
                        end
                    end
                    CAPTURE: begin
                        ts <= produce ? '0 : ts + 1'b1;
                        // Only the newest status survives; an emission in the
                        // same cycle as a new change keeps the new one pending.
                        if (stat_chg) begin
                            pend     <= 1'b1;
                            pend_val <= bus.I_status;
                        end else if (stat_go) begin
                            pend <= 1'b0;
                        end
                        if (data_go || stat_go) time_cnt <= '0;
                        else if (time_go)       time_cnt <= time_nxt;
                        // An event colliding with a MARK is lost and forces another MARK.
                        if (mark_go) begin
                            drop_cnt <= bus.I_event_valid ? 16'd1 : 16'd0;
                            if (bus.I_event_valid) sticky_q <= 1'b1;
                        end else if (produce && bus.I_fifo_full) begin
                            drop_cnt <= drop_nxt;
                            sticky_q <= 1'b1;
                        end
                        if (wr_go) begin
                            wr_q   <= 1'b1;
                            data_q <= word;
                            wcnt   <= wcnt_nxt;
                            if (bus.I_max_words != '0 && wcnt_nxt == bus.I_max_words)
                                state <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.O_data         = data_q;
    assign bus.O_wr           = wr_q;
    assign bus.O_armed        = (state == ARMED);
    assign bus.O_capturing    = (state == CAPTURE);
    assign bus.O_capture_done = (state == DONE);
    assign bus.O_drop_sticky  = sticky_q;
endmodule
